// File: rtl/rata_bus_monitor.sv
// rtl/rata_bus_monitor.sv - CPU/DMA write and PC watcher feeding the RATA_B attestation FSM
// Emits held Mod_Mem pulses for LMT/AR writes, an encoded PC class and a saturating LMT write count.
module rata_bus_monitor #(
    parameter int unsigned              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]        LMT_BASE = 16'h0100,
    parameter logic [ADDR_W-1:0]        LMT_END  = 16'h01FF,
    parameter logic [ADDR_W-1:0]        AR_BASE  = 16'h0200,
    parameter logic [ADDR_W-1:0]        AR_END   = 16'h02FF,
    parameter logic [ADDR_W-1:0]        ATT_BASE = 16'hA000,
    parameter logic [ADDR_W-1:0]        ATT_END  = 16'hAFFF,
    parameter logic [ADDR_W-1:0]        CR_AUTH  = 16'hA800,
    parameter logic [ADDR_W-1:0]        CR_MAX   = 16'hAFFE,
    parameter int unsigned              HOLD     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              dma_en,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              Mod_Mem_LMT,
    output logic              Mod_Mem_AR,
    output logic [1:0]        PC,
    output logic [7:0]        lmt_wr_count
);

    typedef enum logic {IDLE, HOLDING} hold_state_e;

    localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);

    function automatic logic in_rng(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    logic              cpu_wr_q, dma_wr_q;
    logic [ADDR_W-1:0] cpu_addr_q, dma_addr_q;
    logic              cpu_wr, dma_write;
    logic              cpu_evt, dma_evt;
    logic              lmt_evt, ar_evt;
    logic [1:0]        pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;

    // Index 0 drives Mod_Mem_LMT, index 1 drives Mod_Mem_AR.
    hold_state_e       state_q [2];
    hold_state_e       state_d [2];
    logic [3:0]        hcnt_q  [2];
    logic [3:0]        hcnt_d  [2];
    logic              evt     [2];

    assign cpu_wr    = cpu_wr_en;
    assign dma_write = dma_en & dma_wr;

    // A held strobe on an unchanged address is a single event.
    assign cpu_evt = cpu_wr    & (~cpu_wr_q | (cpu_addr != cpu_addr_q));
    assign dma_evt = dma_write & (~dma_wr_q | (dma_addr != dma_addr_q));

    assign lmt_evt = (cpu_evt & in_rng(cpu_addr, LMT_BASE, LMT_END)) |
                     (dma_evt & in_rng(dma_addr, LMT_BASE, LMT_END));
    assign ar_evt  = (cpu_evt & in_rng(cpu_addr, AR_BASE, AR_END)) |
                     (dma_evt & in_rng(dma_addr, AR_BASE, AR_END));

    assign evt[0] = lmt_evt;
    assign evt[1] = ar_evt;

    always_comb begin
        pc_d = 2'b00;
        if (cpu_pc == CR_MAX)
            pc_d = 2'b11;
        else if (cpu_pc == CR_AUTH)
            pc_d = 2'b10;
        else if (in_rng(cpu_pc, ATT_BASE, ATT_END))
            pc_d = 2'b01;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (lmt_evt && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_wr_q   <= 1'b0;
            cpu_addr_q <= '0;
            dma_wr_q   <= 1'b0;
            dma_addr_q <= '0;
            pc_q       <= 2'b00;
            cnt_q      <= 8'h00;
        end else begin
            cpu_wr_q   <= cpu_wr;
            cpu_addr_q <= cpu_addr;
            dma_wr_q   <= dma_write;
            dma_addr_q <= dma_addr;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                hcnt_q[i]  <= 4'd0;
            end else begin
                state_q[i] <= state_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            hcnt_d[i]  = hcnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (evt[i]) begin
                        state_d[i] = HOLDING;
                        hcnt_d[i]  = HOLD_LD;
                    end
                end
                HOLDING: begin
                    if (evt[i])
                        hcnt_d[i] = HOLD_LD;
                    else if (hcnt_q[i] == 4'd0)
                        state_d[i] = IDLE;
                    else
                        hcnt_d[i] = hcnt_q[i] - 4'd1;
                end
                default: begin
                    state_d[i] = IDLE;
                    hcnt_d[i]  = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        Mod_Mem_LMT = (state_q[0] == HOLDING);
        Mod_Mem_AR  = (state_q[1] == HOLDING);
    end

    assign PC           = pc_q;
    assign lmt_wr_count = cnt_q;

endmodule

// File: tb/tb_rata_bus_monitor.sv
// tb/tb_rata_bus_monitor.sv - scoreboard bench for rata_bus_monitor
module tb_rata_bus_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_pc = 16'h1000;
    logic        cpu_wr_en = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        dma_en = 1'b0;
    logic        dma_wr = 1'b0;
    logic [15:0] dma_addr = 16'h0000;
    logic        Mod_Mem_LMT;
    logic        Mod_Mem_AR;
    logic [1:0]  PC;
    logic [7:0]  lmt_wr_count;

    typedef struct packed {
        logic       lmt;
        logic       ar;
        logic [1:0] pc;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   vec_no = 0;

    always #5 clk = ~clk;

    rata_bus_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_pc       (cpu_pc),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_addr     (cpu_addr),
        .dma_en       (dma_en),
        .dma_wr       (dma_wr),
        .dma_addr     (dma_addr),
        .Mod_Mem_LMT  (Mod_Mem_LMT),
        .Mod_Mem_AR   (Mod_Mem_AR),
        .PC           (PC),
        .lmt_wr_count (lmt_wr_count)
    );

    // Inputs for the coming edge, plus the outputs expected right after it.
    task automatic step(input logic r, input logic [15:0] pc,
                        input logic cwe, input logic [15:0] ca,
                        input logic de, input logic dw, input logic [15:0] da,
                        input logic el, input logic ea, input logic [1:0] ep,
                        input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        rst       = r;
        cpu_pc    = pc;
        cpu_wr_en = cwe;
        cpu_addr  = ca;
        dma_en    = de;
        dma_wr    = dw;
        dma_addr  = da;
        e.lmt = el;
        e.ar  = ea;
        e.pc  = ep;
        e.cnt = ec;
        exp_q.push_back(e);
    endtask

    task automatic cpu_w(input logic cwe, input logic [15:0] ca,
                         input logic el, input logic ea, input logic [7:0] ec);
        step(1'b0, 16'h1000, cwe, ca, 1'b0, 1'b0, 16'h0000, el, ea, 2'b00, ec);
    endtask

    task automatic do_reset();
        step(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic pc_chk(input logic [15:0] pc, input logic [1:0] ep);
        step(1'b0, pc, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, ep, 8'h00);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec_no++;
                tests += 4;
                if (Mod_Mem_LMT !== e.lmt) begin
                    fails++;
                    $display("FAIL lmt vec %0d: got %b want %b", vec_no, Mod_Mem_LMT, e.lmt);
                end
                if (Mod_Mem_AR !== e.ar) begin
                    fails++;
                    $display("FAIL ar vec %0d: got %b want %b", vec_no, Mod_Mem_AR, e.ar);
                end
                if (PC !== e.pc) begin
                    fails++;
                    $display("FAIL pc vec %0d: got %b want %b", vec_no, PC, e.pc);
                end
                if (lmt_wr_count !== e.cnt) begin
                    fails++;
                    $display("FAIL cnt vec %0d: got %h want %h", vec_no, lmt_wr_count, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset with a write held on the bus; first free cycle is a rising edge.
        step(1'b1, 16'h1000, 1'b1, 16'h0150, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b1, 16'h1000, 1'b1, 16'h0150, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00);
        cpu_w(1'b1, 16'h0150, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h01);

        // Single LMT write at the region base, then an out-of-range write.
        do_reset();
        cpu_w(1'b1, 16'h0100, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h01);
        cpu_w(1'b1, 16'h0300, 1'b0, 1'b0, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h01);

        // Strobe held on one address: single event.
        do_reset();
        cpu_w(1'b1, 16'h0105, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b1, 16'h0105, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b1, 16'h0105, 1'b0, 1'b0, 8'h01);
        cpu_w(1'b1, 16'h0105, 1'b0, 1'b0, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h01);

        // Address change on the 3rd held cycle retriggers the pulse.
        do_reset();
        cpu_w(1'b1, 16'h0105, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b1, 16'h0105, 1'b1, 1'b0, 8'h01);
        cpu_w(1'b1, 16'h0106, 1'b1, 1'b0, 8'h02);
        cpu_w(1'b1, 16'h0106, 1'b1, 1'b0, 8'h02);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h02);

        // DMA AR write together with CPU LMT write.
        do_reset();
        step(1'b0, 16'h1000, 1'b1, 16'h0110, 1'b1, 1'b1, 16'h0200, 1'b1, 1'b1, 2'b00, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b1, 1'b1, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h01);
        // dma_wr without dma_en is not a write.
        step(1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 2'b00, 8'h01);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h01);
        // CPU and DMA hitting LMT in the same cycle count once.
        step(1'b0, 16'h1000, 1'b1, 16'h0130, 1'b1, 1'b1, 16'h0120, 1'b1, 1'b0, 2'b00, 8'h02);
        cpu_w(1'b0, 16'h0000, 1'b1, 1'b0, 8'h02);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h02);
        // Inclusive end boundaries, and just outside LMT.
        cpu_w(1'b1, 16'h01FF, 1'b1, 1'b0, 8'h03);
        cpu_w(1'b1, 16'h02FF, 1'b1, 1'b1, 8'h03);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b1, 8'h03);
        cpu_w(1'b1, 16'h00FF, 1'b0, 1'b0, 8'h03);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h03);

        // PC classification sweep.
        do_reset();
        pc_chk(16'h1000, 2'b00);
        pc_chk(16'hA004, 2'b01);
        pc_chk(16'hA800, 2'b10);
        pc_chk(16'hAFFE, 2'b11);
        pc_chk(16'hB000, 2'b00);
        pc_chk(16'hA000, 2'b01);
        pc_chk(16'hAFFF, 2'b01);
        pc_chk(16'h9FFF, 2'b00);

        // 260 distinct LMT writes saturate the counter.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            logic [15:0] a;
            logic [7:0]  ec;
            a  = 16'h0100 + 16'(i % 256);
            ec = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
            cpu_w(1'b1, a, 1'b1, 1'b0, ec);
        end
        // Reset in the middle of a hold wins.
        step(1'b1, 16'h1000, 1'b1, 16'h0104, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00);
        cpu_w(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);

        repeat (5) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
